// File: rtl/pong_input_conditioner_if.sv
// pong_input_conditioner_if: raw push-button inputs and conditioned game controls
interface pong_input_conditioner_if;
    logic raw_btn_1_up;
    logic raw_btn_1_down;
    logic raw_btn_2_up;
    logic raw_btn_2_down;
    logic raw_pause_n;
    logic btn_1_up;
    logic btn_1_down;
    logic btn_2_up;
    logic btn_2_down;
    logic pause;
    logic tick_100hz;
    logic press_any;
    modport master (
        output raw_btn_1_up, raw_btn_1_down, raw_btn_2_up, raw_btn_2_down, raw_pause_n,
        input  btn_1_up, btn_1_down, btn_2_up, btn_2_down, pause, tick_100hz, press_any
    );
    modport slave (
        input  raw_btn_1_up, raw_btn_1_down, raw_btn_2_up, raw_btn_2_down, raw_pause_n,
        output btn_1_up, btn_1_down, btn_2_up, btn_2_down, pause, tick_100hz, press_any
    );
endinterface

// File: rtl/pong_input_conditioner.sv
// pong_input_conditioner: synchronizes and debounces pong buttons, toggles pause, makes the game tick
module pong_input_conditioner #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input logic                     CLOCK_50,
    input logic                     reset,
    pong_input_conditioner_if.slave io
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW = $clog2(DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [4:0]    raw;
    logic [4:0]    sync_1;
    logic [4:0]    sync_2;
    logic [4:0]    stable;
    logic [4:0]    stable_q;
    logic [CW-1:0] cnt [5];
    logic          press;
    logic          pause_lvl;
    assign raw = {io.raw_pause_n, io.raw_btn_2_down, io.raw_btn_2_up, io.raw_btn_1_down, io.raw_btn_1_up};
    // free-running divider; tick is registered so it lands on the DIV-th cycle after reset release
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            tick    <= (div_cnt == DIV_LAST);
        end
    end
    // two-flop synchronizers, reset to the released level
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_1 <= '1;
            sync_2 <= '1;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end
    // per-channel debounce: accept a new level once it has differed from stable for DEBOUNCE_CYCLES cycles
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < 5; i++) begin
            if (reset) begin
                cnt[i]    <= '0;
                stable[i] <= 1'b1;
            end else if (sync_2[i] == stable[i]) begin
                cnt[i] <= '0;
            end else if (cnt[i] >= CNT_LAST) begin
                cnt[i]    <= '0;
                stable[i] <= sync_2[i];
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end
    // press edges: one-cycle press_any for any player press, pause toggles once per accepted press
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            stable_q  <= '1;
            press     <= 1'b0;
            pause_lvl <= 1'b0;
        end else begin
            stable_q  <= stable;
            press     <= |(stable_q[3:0] & ~stable[3:0]);
            pause_lvl <= pause_lvl ^ (stable_q[4] & ~stable[4]);
        end
    end
    assign io.btn_1_up   = stable[0];
    assign io.btn_1_down = stable[1];
    assign io.btn_2_up   = stable[2];
    assign io.btn_2_down = stable[3];
    assign io.pause      = pause_lvl;
    assign io.tick_100hz = tick;
    assign io.press_any  = press;
endmodule

// File: tb/tb_pong_input_conditioner.sv
// tb_pong_input_conditioner: directed and random checks against a hold-time reference model
module tb_pong_input_conditioner;
    localparam int DEB = 4;
    localparam int DIV = 10;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] raw;
    int         total;
    int         bad;
    int         press_cnt;
    int         ticks;
    int         n;
    logic [15:0] hist [5];
    logic [4:0]  m_st;
    logic [4:0]  m_fall;
    logic        m_pause;
    logic        m_press;
    logic        m_tick;
    pong_input_conditioner_if io ();
    assign io.raw_btn_1_up   = raw[0];
    assign io.raw_btn_1_down = raw[1];
    assign io.raw_btn_2_up   = raw[2];
    assign io.raw_btn_2_down = raw[3];
    assign io.raw_pause_n    = raw[4];
    pong_input_conditioner #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(DEB)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .io       (io)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic model_edge();
        logic [4:0] nf;
        if (rst) begin
            for (int c = 0; c < 5; c++) hist[c] = '1;
            m_st = '1; m_fall = '0; m_pause = 1'b0; m_press = 1'b0; m_tick = 1'b0; n = 0;
        end else begin
            n++;
            m_tick  = (n % DIV == 0);
            m_press = |m_fall[3:0];
            m_pause = m_pause ^ m_fall[4];
            nf = '0;
            for (int c = 0; c < 5; c++) begin
                hist[c] = {hist[c][14:0], raw[c]};
                if (hist[c][DEB+1:2] == {DEB{~m_st[c]}}) begin
                    m_st[c] = ~m_st[c];
                    nf[c]   = ~m_st[c];
                end
            end
            m_fall = nf;
        end
    endtask
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        press_cnt += int'(io.press_any);
        chk(tag, {1'b0, io.pause, io.press_any, io.tick_100hz, io.btn_2_down, io.btn_2_up, io.btn_1_down, io.btn_1_up},
            {1'b0, m_pause, m_press, m_tick, m_st[3:0]});
    endtask
    task automatic run(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) step(tag);
    endtask
    initial begin
        total = 0; bad = 0; press_cnt = 0; ticks = 0; n = 0;
        rst = 1'b1; raw = '1;
        for (int c = 0; c < 5; c++) hist[c] = '1;
        m_st = '1; m_fall = '0; m_pause = 1'b0; m_press = 1'b0; m_tick = 1'b0;
        run(3, "reset");
        chk("reset_outs", {1'b0, io.pause, io.press_any, io.tick_100hz, io.btn_2_down, io.btn_2_up, io.btn_1_down, io.btn_1_up}, 8'h0F);
        rst = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            step("tick");
            if (io.tick_100hz) ticks++;
            if (k == 10) chk("tick_first", 8'(io.tick_100hz), 8'd1);
        end
        chk("tick_count", 8'(ticks), 8'd3);
        press_cnt = 0;
        raw[0] = 1'b0;
        run(5, "clean_press");
        chk("b1u_hold", 8'(io.btn_1_up), 8'd1);
        step("clean_press");
        chk("b1u_fall", 8'(io.btn_1_up), 8'd0);
        chk("press_lag", 8'(io.press_any), 8'd0);
        step("clean_press");
        chk("press_pulse", 8'(io.press_any), 8'd1);
        step("clean_press");
        chk("press_end", 8'(io.press_any), 8'd0);
        run(4, "clean_hold");
        raw[0] = 1'b1;
        run(5, "clean_release");
        chk("b1u_low", 8'(io.btn_1_up), 8'd0);
        step("clean_release");
        chk("b1u_rise", 8'(io.btn_1_up), 8'd1);
        run(3, "clean_release");
        chk("press_once", 8'(press_cnt), 8'd1);
        press_cnt = 0;
        raw[3] = 1'b0;
        run(3, "bounce");
        raw[3] = 1'b1;
        step("bounce");
        raw[3] = 1'b0;
        run(5, "bounce");
        chk("b2d_hold", 8'(io.btn_2_down), 8'd1);
        step("bounce");
        chk("b2d_fall", 8'(io.btn_2_down), 8'd0);
        run(4, "bounce");
        chk("bounce_press_once", 8'(press_cnt), 8'd1);
        raw[3] = 1'b1;
        run(8, "bounce_release");
        raw[4] = 1'b0;
        run(20, "pause_1");
        chk("pause_on", 8'(io.pause), 8'd1);
        raw[4] = 1'b1;
        run(20, "pause_rel");
        chk("pause_rel", 8'(io.pause), 8'd1);
        raw[4] = 1'b0;
        run(20, "pause_2");
        chk("pause_off", 8'(io.pause), 8'd0);
        raw[4] = 1'b1;
        run(10, "pause_rel");
        press_cnt = 0;
        raw[3:0] = 4'h0;
        run(5, "simul");
        chk("simul_hold", {4'h0, io.btn_2_down, io.btn_2_up, io.btn_1_down, io.btn_1_up}, 8'h0F);
        step("simul");
        chk("simul_fall", {4'h0, io.btn_2_down, io.btn_2_up, io.btn_1_down, io.btn_1_up}, 8'h00);
        run(5, "simul");
        chk("simul_press_once", 8'(press_cnt), 8'd1);
        raw[3:0] = 4'hF;
        run(8, "simul_release");
        raw[1] = 1'b0;
        run(3, "mid_reset");
        rst = 1'b1;
        step("mid_reset");
        chk("mid_rst_b1d", 8'(io.btn_1_down), 8'd1);
        rst = 1'b0;
        run(5, "mid_reset");
        chk("mid_b1d_hold", 8'(io.btn_1_down), 8'd1);
        step("mid_reset");
        chk("mid_b1d_fall", 8'(io.btn_1_down), 8'd0);
        run(3, "mid_reset");
        chk("mid_tick_9", 8'(io.tick_100hz), 8'd0);
        step("mid_reset");
        chk("mid_tick_10", 8'(io.tick_100hz), 8'd1);
        raw[1] = 1'b1;
        run(8, "mid_release");
        raw[4] = 1'b0;
        run(8, "pause_reset");
        chk("pause_pre_rst", 8'(io.pause), 8'd1);
        rst = 1'b1;
        step("pause_reset");
        chk("pause_in_rst", 8'(io.pause), 8'd0);
        rst = 1'b0;
        run(6, "pause_reset");
        chk("pause_wait", 8'(io.pause), 8'd0);
        step("pause_reset");
        chk("pause_reaccept", 8'(io.pause), 8'd1);
        raw[4] = 1'b1;
        run(8, "pause_release");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) raw ^= 5'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            step("random");
        end
        rst = 1'b0;
        raw = '1;
        run(10, "final");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
